// File: rtl/bitcoin_mem_responder.sv
// bitcoin_mem_responder: word RAM plus run FSM serving the bitcoin_hash mem_* interface.
// Optional MEM_BOUNDS_CHECK_EN adds sticky out-of-range detection (addr_err/err_addr).
module bitcoin_mem_responder #(
  parameter int DEPTH          = 256,
  parameter int EXPECT_WRITES  = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  input  logic        host_go,
  output logic        busy,
  output logic        complete,
  output logic        timeout,
  output logic [7:0]  wr_count,
  output logic        hash_start,
  input  logic        hash_done,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data
`ifdef MEM_BOUNDS_CHECK_EN
  ,
  output logic        addr_err,
  output logic [15:0] err_addr
`endif
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);
  localparam logic [7:0] EXP_W = 8'(EXPECT_WRITES);
  localparam logic [15:0] T_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, KICK, RUN, DONE, ERROR} state_e;

  state_e      state_q, state_d;
  logic [7:0]  wr_count_q, wr_count_d;
  logic [15:0] timer_q, timer_d;
  logic [31:0] mem_rdata_q, host_rdata_q;
  logic [31:0] ram [DEPTH];
  logic        mem_in, host_in, host_ok, go, done_cond, tmo_cond;

  assign mem_in    = {1'b0, mem_addr} < DEPTH_W;
  assign host_in   = {1'b0, host_addr} < DEPTH_W;
  assign host_ok   = state_q == IDLE || state_q == DONE || state_q == ERROR;
  assign go        = host_ok && host_go;
  assign done_cond = hash_done && wr_count_q >= EXP_W;
  assign tmo_cond  = timer_q == T_LAST;

  // Hasher write is applied last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (host_we && host_in && host_ok) ram[host_addr[AW-1:0]] <= host_wdata;
    if (mem_we && mem_in) ram[mem_addr[AW-1:0]] <= mem_write_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      mem_rdata_q  <= mem_in ? ram[mem_addr[AW-1:0]] : '0;
      host_rdata_q <= host_in ? ram[host_addr[AW-1:0]] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_count_q <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      timer_q    <= timer_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    timer_d    = timer_q;
    if (go) begin
      state_d    = KICK;
      wr_count_d = '0;
      timer_d    = '0;
    end else if (state_q == KICK) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      timer_d    = timer_q + 16'd1;
      wr_count_d = (mem_we && mem_in && wr_count_q != 8'hFF) ? wr_count_q + 8'd1 : wr_count_q;
      state_d    = done_cond ? DONE : tmo_cond ? ERROR : RUN;
    end
  end

  assign busy          = state_q == KICK || state_q == RUN;
  assign complete      = state_q == DONE;
  assign timeout       = state_q == ERROR;
  assign hash_start    = state_q == KICK;
  assign wr_count      = wr_count_q;
  assign host_rdata    = host_rdata_q;
  assign mem_read_data = mem_rdata_q;

`ifdef MEM_BOUNDS_CHECK_EN
  logic        addr_err_q, addr_err_d;
  logic [15:0] err_addr_q, err_addr_d;

  // Only the first offending address of a run is latched.
  always_comb begin
    addr_err_d = addr_err_q;
    err_addr_d = err_addr_q;
    if (go) begin
      addr_err_d = 1'b0;
      err_addr_d = '0;
    end else if (busy && !mem_in && !addr_err_q) begin
      addr_err_d = 1'b1;
      err_addr_d = mem_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_err_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      addr_err_q <= addr_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign addr_err = addr_err_q;
  assign err_addr = err_addr_q;
`endif
endmodule

// File: tb/tb_bitcoin_mem_responder.sv
// tb_bitcoin_mem_responder: randomized self-checking bench with an array model of the RAM
// and run-level expectations derived from the responder's rules.
module tb_bitcoin_mem_responder;
  localparam int DEPTH = 256;
  localparam int EXPW  = 16;
  localparam int TMO   = 100;

  logic        clk, reset_n, host_we, host_go, hash_done, mem_we;
  logic [15:0] host_addr, mem_addr;
  logic [31:0] host_wdata, mem_write_data, host_rdata, mem_read_data;
  logic        busy, complete, timeout, hash_start;
  logic [7:0]  wr_count;
`ifdef MEM_BOUNDS_CHECK_EN
  logic        addr_err;
  logic [15:0] err_addr;
`endif

  bitcoin_mem_responder #(.DEPTH(DEPTH), .EXPECT_WRITES(EXPW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_go(host_go), .busy(busy),
    .complete(complete), .timeout(timeout), .wr_count(wr_count), .hash_start(hash_start),
    .hash_done(hash_done), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
`ifdef MEM_BOUNDS_CHECK_EN
    , .addr_err(addr_err), .err_addr(err_addr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] mm [DEPTH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd(input int a);
    return (a >= DEPTH) ? 32'h0 : mm[a];
  endfunction

  task automatic host_read(input int a, input string tag);
    host_addr = 16'(a);
    tick();
    chk(tag, host_rdata, rd(a));
  endtask

  task automatic go_pulse();
    host_go = 1'b1;
    tick();
    host_go = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [31:0] d;
    reset_n = 1'b0; host_we = 0; host_go = 0; hash_done = 0; mem_we = 0;
    host_addr = 0; mem_addr = 16'h0010; host_wdata = 0; mem_write_data = 0;
    #12;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_complete", {31'b0, complete}, 0);
    chk("rst_timeout", {31'b0, timeout}, 0);
    chk("rst_hash_start", {31'b0, hash_start}, 0);
    chk("rst_wr_count", {24'b0, wr_count}, 0);
    chk("rst_mem_rdata", mem_read_data, 0);
    chk("rst_host_rdata", host_rdata, 0);
    reset_n = 1'b1;
    tick();
    // preload the whole RAM so every model word is known
    for (int a = 0; a < DEPTH; a++) begin
      host_we = 1'b1; host_addr = 16'(a); host_wdata = $urandom; mm[a] = host_wdata;
      tick();
    end
    host_we = 1'b1; host_addr = 16'h0010; host_wdata = 32'hDEADBEEF; mm[16] = 32'hDEADBEEF;
    tick();
    host_we = 1'b0;
    tick();
    chk("host_rb_deadbeef", host_rdata, 32'hDEADBEEF);
    mem_addr = 16'h0010;
    tick();
    chk("mem_rd_deadbeef", mem_read_data, 32'hDEADBEEF);
    mem_we = 1'b1; mem_write_data = 32'h1;
    tick();
    chk("mem_rd_old_word", mem_read_data, 32'hDEADBEEF);
    mm[16] = 32'h1;
    mem_we = 1'b0;
    tick();
    chk("mem_rd_new_word", mem_read_data, 32'h1);
    // random idle traffic on both ports, including out-of-range and collisions
    for (int i = 0; i < 60; i++) begin
      int ha, ma;
      logic [31:0] em, eh;
      ha = int'($urandom_range(0, 299)); ma = (i % 7 == 0) ? ha : int'($urandom_range(0, 299));
      host_we = 1'($urandom); host_addr = 16'(ha); host_wdata = $urandom;
      mem_we = 1'($urandom); mem_addr = 16'(ma); mem_write_data = $urandom;
      em = rd(ma); eh = rd(ha);
      tick();
      chk("rand_mem_rd", mem_read_data, em);
      chk("rand_host_rd", host_rdata, eh);
      if (host_we && ha < DEPTH) mm[ha] = host_wdata;
      if (mem_we && ma < DEPTH) mm[ma] = mem_write_data;
    end
    host_we = 0; mem_we = 0; mem_addr = 16'h0010;
    for (int i = 0; i < 4; i++) host_read(int'($urandom_range(0, 299)), "rand_host_final");
    // normal run: 16 writes then hash_done
    go_pulse();
    chk("kick_hash_start", {31'b0, hash_start}, 1);
    chk("kick_busy", {31'b0, busy}, 1);
    tick();
    chk("run_hash_start_low", {31'b0, hash_start}, 0);
    chk("run_busy", {31'b0, busy}, 1);
    for (int k = 0; k < 16; k++) begin
      mem_we = 1'b1; mem_addr = 16'(16'h00B0 + k); mem_write_data = $urandom;
      mm[16'h00B0 + k] = mem_write_data;
      host_we = 1'b1; host_addr = 16'(16'h00B0 + k); host_wdata = $urandom;
      tick();
    end
    mem_we = 0; host_we = 0; mem_addr = 16'h0010;
    chk("run_wr_count16", {24'b0, wr_count}, 16);
    chk("run_not_complete", {31'b0, complete}, 0);
    hash_done = 1'b1;
    tick();
    hash_done = 1'b0;
    chk("done_complete", {31'b0, complete}, 1);
    chk("done_busy", {31'b0, busy}, 0);
    chk("done_wr_count", {24'b0, wr_count}, 16);
    for (int k = 0; k < 16; k++) host_read(16'h00B0 + k, "done_ram_b0");
    // stale hash_done high from the start; out-of-range write first
    hash_done = 1'b1;
    go_pulse();
    chk("run2_complete_cleared", {31'b0, complete}, 0);
    tick();
    mem_we = 1'b1; mem_addr = 16'h0100; mem_write_data = 32'hFFFF_FFFF;
    tick();
    chk("oor_wr_count", {24'b0, wr_count}, 0);
    chk("oor_read_zero", mem_read_data, 0);
`ifdef MEM_BOUNDS_CHECK_EN
    chk("oor_addr_err", {31'b0, addr_err}, 1);
    chk("oor_err_addr", {16'b0, err_addr}, 32'h0100);
`endif
    for (int k = 0; k < 16; k++) begin
      mem_we = 1'b1; mem_addr = 16'(16'h00C0 + k); mem_write_data = $urandom;
      mm[16'h00C0 + k] = mem_write_data;
      tick();
      chk("stale_done_no_complete", {31'b0, complete}, 0);
    end
    mem_we = 0; mem_addr = 16'h0010;
    tick();
    chk("stale_done_complete", {31'b0, complete}, 1);
    hash_done = 1'b0;
    host_read(16'h00CF, "run2_ram_cf");
    host_read(0, "oor_ram_0_untouched");
    // timeout: count RUN cycles until ERROR
    go_pulse();
    chk("tmo_kick", {31'b0, hash_start}, 1);
`ifdef MEM_BOUNDS_CHECK_EN
    chk("go_clears_addr_err", {31'b0, addr_err}, 0);
`endif
    tick();
    host_we = 1'b1; host_addr = 16'h0030; host_wdata = ~mm[48];
    cnt = 0;
    while (!timeout && cnt < 300) begin
      tick();
      host_we = 1'b0;
      cnt++;
    end
    chk("tmo_run_cycles", cnt, TMO);
    chk("tmo_busy", {31'b0, busy}, 0);
    host_read(16'h0030, "run_host_write_dropped");
    d = $urandom;
    host_we = 1'b1; host_addr = 16'h0030; host_wdata = d; mm[48] = d;
    tick();
    host_we = 1'b0;
    host_read(16'h0030, "err_host_write_ok");
    // reset mid-run
    go_pulse();
    chk("go_clears_timeout", {31'b0, timeout}, 0);
    tick();
    mem_we = 1'b1; mem_addr = 16'h0020; mem_write_data = $urandom; mm[32] = mem_write_data;
    tick();
    mem_we = 1'b0; mem_addr = 16'h0010;
    chk("pre_rst_wr_count", {24'b0, wr_count}, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_wr_count", {24'b0, wr_count}, 0);
    chk("mid_rst_mem_rdata", mem_read_data, 0);
    chk("mid_rst_complete", {31'b0, complete | timeout | hash_start}, 0);
    #1 reset_n = 1'b1;
    tick();
    host_read(16'h0020, "ram_kept_after_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
